pair_reduce_seq: RTL



---
 rtl/pair_reduce_seq_if.sv | 38 +++
 rtl/pair_reduce_seq.sv | 119 +++++++++++
 2 files changed

// File: rtl/pair_reduce_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : pair_reduce_seq_if
// Purpose  : Handshake bundle for pair_reduce_seq. The producer side offers an
//            operand bus plus op select; the consumer side receives the
//            per-pair result flags.
// Signals  : in_data   [WIDTH]    operand bus            (producer -> block)
//            in_mode   [2]        op select              (producer -> block)
//            in_valid  [1]        operand offered        (producer -> block)
//            in_ready  [1]        block can accept       (block -> producer)
//            out_pairs [WIDTH/2]  per-pair result        (block -> consumer)
//            out_valid [1]        result valid           (block -> consumer)
//            out_ready [1]        consumer accepts       (consumer -> block)
// Modports : master = producer/consumer environment, slave = the block.
// Revision : 1.0  initial release
// ============================================================================
interface pair_reduce_seq_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_mode;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH/2-1:0] out_pairs;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_mode, in_valid, out_ready,
    input  in_ready, out_pairs, out_valid
  );

  modport slave (
    input  in_data, in_mode, in_valid, out_ready,
    output in_ready, out_pairs, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/pair_reduce_seq.sv
`default_nettype none
// ============================================================================
// Module   : pair_reduce_seq
// Purpose  : Splits a WIDTH-bit operand into WIDTH/2 adjacent bit pairs and
//            reduces each pair with a selectable op (AND/OR/XOR/XNOR),
//            evaluating LANES pairs per cycle. Result bit k is
//            op(in_data[2k+1], in_data[2k]).
// Ports    : clk   - single clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - pair_reduce_seq_if.slave handshake bundle
// Params   : WIDTH - operand width, even and >= 2
//            LANES - pairs per cycle, must divide WIDTH/2
// Timing   : out_valid rises WIDTH/(2*LANES) edges after the accept edge;
//            one transaction per STEPS+2 cycles at most.
// Revision : 1.0  initial release
// ============================================================================
module pair_reduce_seq #(
  parameter int WIDTH = 8,
  parameter int LANES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  pair_reduce_seq_if.slave  bus
);

  localparam int NPAIRS = WIDTH / 2;
  localparam int STEPS  = WIDTH / (2 * LANES);
  localparam int CW     = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [1:0]        mode_q,  mode_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic [NPAIRS-1:0] result_q, result_d;
  logic [LANES-1:0]  lane_res;

  // Lane j always looks at pair j of the shift register; the register is
  // shifted down so that successive steps present successive pair groups.
  always_comb begin
    lane_res = '0;
    for (int j = 0; j < LANES; j++) begin
      case (mode_q)
        2'b00:   lane_res[j] =   shreg_q[2*j+1] & shreg_q[2*j];
        2'b01:   lane_res[j] =   shreg_q[2*j+1] | shreg_q[2*j];
        2'b10:   lane_res[j] =   shreg_q[2*j+1] ^ shreg_q[2*j];
        default: lane_res[j] = ~(shreg_q[2*j+1] ^ shreg_q[2*j]);
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shreg_d  = bus.in_data;
          mode_d   = bus.in_mode;
          cnt_d    = '0;
          result_d = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        shreg_d = shreg_q >> (2 * LANES);
        cnt_d   = cnt_q + 1'b1;
        // Unrolled over steps so every result bit index is a constant.
        for (int s = 0; s < STEPS; s++) begin
          if (cnt_q == CW'(s)) begin
            for (int j = 0; j < LANES; j++) begin
              result_d[s*LANES+j] = lane_res[j];
            end
          end
        end
        if (cnt_q == LAST_STEP) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      mode_q   <= 2'b00;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_pairs = result_q;

endmodule
`default_nettype wire
